// File: rtl/ws2812_frame_scheduler.sv
// ws2812_frame_scheduler: frames upstream bytes into LED_COUNT*3-byte WS2812 frames with a latch gap; WS2812_SCHED_HOLD_ON_UNDERRUN_EN repeats the last byte on underrun.
module ws2812_frame_scheduler #(
  parameter int LED_COUNT    = 60,
  parameter int LATCH_CYCLES = 1000,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_start,
  input  logic       out_request,
  input  logic       tx_idle,
  output logic       frame_sync,
  output logic       busy,
  output logic       underrun
);
  localparam logic [CNT_W-1:0] TOTAL      = CNT_W'(LED_COUNT * 3);
  localparam logic [CNT_W-1:0] LAST_LATCH = CNT_W'(LATCH_CYCLES - 1);
  typedef enum logic [2:0] {LATCH, FILL, START, STREAM, DRAIN} state_t;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] latch_cnt, latch_nxt, acc_cnt, acc_nxt, sent_cnt, sent_nxt;
  logic [7:0]       hold_data, hold_data_nxt, out_data_nxt, gap_byte;
  logic             hold_full, hold_full_nxt, underrun_nxt, ready_nxt;
`ifdef WS2812_SCHED_HOLD_ON_UNDERRUN_EN
  assign gap_byte = out_data;
`else
  assign gap_byte = 8'h00;
`endif
  assign busy = state == START || state == STREAM || state == DRAIN;
  always_comb begin
    state_nxt     = state;
    latch_nxt     = latch_cnt;
    acc_nxt       = acc_cnt;
    sent_nxt      = sent_cnt;
    hold_data_nxt = hold_data;
    hold_full_nxt = hold_full;
    out_data_nxt  = out_data;
    underrun_nxt  = underrun;
    if (in_valid && in_ready) begin
      hold_data_nxt = in_data;
      hold_full_nxt = 1'b1;
      acc_nxt       = acc_cnt + 1'b1;
    end
    case (state)
      LATCH: begin
        latch_nxt = latch_cnt + 1'b1;
        if (latch_cnt == LAST_LATCH) begin
          state_nxt = FILL;
          latch_nxt = '0;
          acc_nxt   = '0;
          sent_nxt  = '0;
        end
      end
      FILL: state_nxt = hold_full ? START : FILL;
      START: begin
        out_data_nxt  = hold_data;
        hold_full_nxt = 1'b0;
        sent_nxt      = CNT_W'(1);
        state_nxt     = STREAM;
      end
      STREAM: if (out_request) begin
        if (sent_cnt == TOTAL) state_nxt = DRAIN;
        else begin
          sent_nxt = sent_cnt + 1'b1;
          if (hold_full) begin
            out_data_nxt  = hold_data;
            hold_full_nxt = 1'b0;
          end else begin
            // missing byte: burn the slot so the frame length stays fixed
            out_data_nxt = gap_byte;
            underrun_nxt = 1'b1;
            acc_nxt      = acc_nxt + 1'b1;
          end
        end
      end
      DRAIN: if (tx_idle) begin
        state_nxt = LATCH;
        latch_nxt = '0;
      end
      default: state_nxt = LATCH;
    endcase
    // look-ahead on hold/acc keeps in_ready registered yet never double-accepts
    ready_nxt = !hold_full_nxt && acc_nxt < TOTAL && (state == FILL || state == START || state == STREAM);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LATCH;
      latch_cnt  <= '0;
      acc_cnt    <= '0;
      sent_cnt   <= '0;
      hold_data  <= '0;
      hold_full  <= 1'b0;
      out_data   <= '0;
      out_start  <= 1'b0;
      frame_sync <= 1'b0;
      in_ready   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      latch_cnt  <= latch_nxt;
      acc_cnt    <= acc_nxt;
      sent_cnt   <= sent_nxt;
      hold_data  <= hold_data_nxt;
      hold_full  <= hold_full_nxt;
      out_data   <= out_data_nxt;
      out_start  <= state == START;
      frame_sync <= state == LATCH && latch_cnt == LAST_LATCH;
      in_ready   <= ready_nxt;
      underrun   <= underrun_nxt;
    end
  end
endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// tb_ws2812_frame_scheduler: randomized frame/underrun/reset scenarios against a byte-queue model of the scheduler.
module tb_ws2812_frame_scheduler;
  localparam int TOTAL = 6;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0, out_request = 1'b0, tx_idle = 1'b0;
  logic       in_ready, out_start, frame_sync, busy, underrun;
  logic [7:0] out_data;
  int         checks = 0, failures = 0;
  bit         exp_under = 1'b0;

  ws2812_frame_scheduler #(.LED_COUNT(2), .LATCH_CYCLES(10), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_start(out_start), .out_request(out_request), .tx_idle(tx_idle),
    .frame_sync(frame_sync), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // idle until frame_sync, expecting it exp_n negedges from now
  task automatic wait_latch(input int exp_n, input bit stray);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 60) begin
      out_request = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      n++;
      if (frame_sync) seen = 1'b1;
      else begin
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL latch_idle ready=%b busy=%b expected 0/0", in_ready, busy);
        end
      end
    end
    out_request = 1'b0;
    checks++;
    if (!seen || n != exp_n) begin
      failures++;
      $display("FAIL latch_gap cycles=%0d expected=%0d seen=%b", n, exp_n, seen);
    end
  endtask

  // mode 0 steady, 1 forced underrun on slot 3, 2 random stalls, 3 stray requests; abort_at>0 resets after that many bytes
  task automatic run_frame(input int mode, input int abort_at);
    logic [7:0] src[TOTAL];
    logic [7:0] q[$];
    logic [7:0] exp, last;
    int a = 0, burn = 0, sent = 0, gap = 0, cyc = 0;
    bit started = 1'b0, done = 1'b0, acc_p, req_p, req, offer;
    last = 8'h00;
    for (int k = 0; k < TOTAL; k++) src[k] = (mode == 2) ? 8'($urandom) : 8'((k + 1) * 17);
    tx_idle = 1'b0;
    if (mode == 3) begin
      repeat (3) begin
        in_valid = 1'b0;
        out_request = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_start !== 1'b0) begin
          failures++;
          $display("FAIL stray_fill busy=%b start=%b expected 0/0", busy, out_start);
        end
      end
      out_request = 1'b0;
    end
    while (!done && cyc < 400) begin
      req = started && gap == 0;
      if (req) gap = $urandom_range(1, 4);
      else if (started && gap > 0) gap--;
      offer = !req && (a + burn < TOTAL) && !(mode == 1 && a + burn == 2 && sent < 3)
              && (mode != 2 || $urandom_range(0, 3) != 0);
      out_request = req;
      in_valid = offer;
      in_data = (a + burn < TOTAL) ? src[a + burn] : 8'h00;
      acc_p = in_valid && in_ready;
      req_p = req;
      @(negedge clk);
      cyc++;
      if (acc_p) begin
        q.push_back(in_data);
        a++;
      end
      if (out_start) begin
        exp = (q.size() > 0) ? q[0] : 8'h00;
        checks++;
        if (started || q.size() == 0 || out_data !== exp) begin
          failures++;
          $display("FAIL frame_start data=%h expected=%h repeat=%b", out_data, exp, started);
        end
        if (q.size() > 0) last = q.pop_front();
        started = 1'b1;
        sent = 1;
        gap = 1;
      end
      if (req_p) begin
        if (sent == TOTAL) begin
          checks++;
          if (out_data !== last || busy !== 1'b1) begin
            failures++;
            $display("FAIL drain_enter data=%h busy=%b expected %h/1", out_data, busy, last);
          end
          done = 1'b1;
        end else begin
          if (q.size() > 0) exp = q.pop_front();
          else begin
`ifdef WS2812_SCHED_HOLD_ON_UNDERRUN_EN
            exp = last;
`else
            exp = 8'h00;
`endif
            burn++;
            exp_under = 1'b1;
          end
          last = exp;
          sent++;
          checks++;
          if (out_data !== exp || underrun !== exp_under) begin
            failures++;
            $display("FAIL byte%0d data=%h underrun=%b expected %h/%b", sent, out_data, underrun, exp, exp_under);
          end
          if (sent == abort_at) begin
            out_request = 1'b0;
            in_valid = 1'b0;
            #2 rst = 1'b1;
            #1;
            checks++;
            if ({out_data, out_start, frame_sync, in_ready, underrun, busy} !== 13'd0) begin
              failures++;
              $display("FAIL async_reset data=%h start=%b sync=%b ready=%b under=%b busy=%b expected all 0",
                       out_data, out_start, frame_sync, in_ready, underrun, busy);
            end
            exp_under = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            wait_latch(10, 1'b0);
            return;
          end
        end
      end
      if (a + burn >= TOTAL) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL ready_after_full ready=%b expected=0", in_ready);
        end
      end
    end
    out_request = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (!done || a + burn != TOTAL) begin
      failures++;
      $display("FAIL frame_complete done=%b slots=%0d expected 1/%0d", done, a + burn, TOTAL);
    end
    repeat ($urandom_range(2, 6)) begin
      out_request = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || out_data !== last) begin
        failures++;
        $display("FAIL drain_hold busy=%b data=%h expected 1/%h", busy, out_data, last);
      end
    end
    out_request = 1'b0;
    tx_idle = 1'b1;
    wait_latch(11, mode == 3);
    tx_idle = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_data, out_start, frame_sync, in_ready, underrun, busy} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs data=%h start=%b sync=%b ready=%b under=%b busy=%b expected all 0",
               out_data, out_start, frame_sync, in_ready, underrun, busy);
    end
    rst = 1'b0;
    wait_latch(10, 1'b0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || frame_sync !== 1'b0) begin
      failures++;
      $display("FAIL post_sync ready=%b sync=%b expected 1/0", in_ready, frame_sync);
    end
  endtask

  task automatic test_normal_frame;
    run_frame(0, 0);
  endtask

  task automatic test_stray_requests;
    run_frame(3, 0);
    run_frame(0, 0);
  endtask

  task automatic test_underrun;
    run_frame(1, 0);
  endtask

  task automatic test_random_frames;
    for (int i = 0; i < 4; i++) run_frame(2, 0);
  endtask

  task automatic test_reset_mid_stream;
    run_frame(0, 4);
    run_frame(0, 0);
  endtask

  initial begin
    test_reset;
    test_normal_frame;
    test_stray_requests;
    test_underrun;
    test_random_frames;
    test_reset_mid_stream;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ws2812_frame_scheduler.md
Name: ws2812_frame_scheduler

Overview:
- Sits between the colour pipeline (fader plus gamma stage) and the WS2812 output shifter.
- Buffers one byte from upstream and hands bytes to the shifter on request.
- Frames the stream into exactly LED_COUNT*3 bytes, then enforces the WS2812 latch (reset) gap before the next frame.
- Raises a per-frame sync pulse so upstream can restart its pixel walk.

Parameters:
- LED_COUNT, 60: LEDs per strip; one frame is TOTAL = LED_COUNT*3 bytes.
- LATCH_CYCLES, 1000: clk cycles of idle line after the last bit (1000 cycles = 83 us at 12 MHz).
- CNT_W, 16: width of the byte counters and the latch counter; must hold max(TOTAL, LATCH_CYCLES).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  8  colour byte from the gamma stage
- in_valid  in  1  in_data is valid
- in_ready  out  1  byte accepted on the clk edge where in_valid & in_ready
- out_data  out  8  byte presented to the shifter
- out_start  out  1  1-cycle pulse: shifter begins a frame with out_data
- out_request  in  1  1-cycle pulse from the shifter: current byte latched, next wanted
- tx_idle  in  1  shifter line idle (low), all bits sent
- frame_sync  out  1  1-cycle pulse at the start of each frame window
- busy  out  1  high in START/STREAM/DRAIN
- underrun  out  1  sticky: a byte was missing when requested

Behaviour:
- Reset (asynchronous): state=LATCH with counter=0; out_data=0, out_start=0, frame_sync=0, in_ready=0, underrun=0, busy=0, hold buffer empty, both counters 0. Reset mid-frame aborts immediately with no partial-frame completion.
- Internal state: one hold register (hold_data, hold_full), acc_cnt (slots filled/burned), sent_cnt (bytes given to the shifter).
- in_ready = !hold_full && acc_cnt<TOTAL && state in {FILL, START, STREAM}. Registered output, no combinational path from out_request.
- Accepting a byte: hold_data<=in_data, hold_full<=1, acc_cnt++.
- LATCH: counter increments each cycle. At LATCH_CYCLES-1: go to FILL, pulse frame_sync in the FILL entry cycle, clear acc_cnt and sent_cnt.
- FILL: wait for hold_full, then go to START.
- START (1 cycle): out_data<=hold_data, hold_full<=0, sent_cnt<=1, out_start=1, then STREAM.
- STREAM, on out_request:
  - If sent_cnt==TOTAL: go to DRAIN; out_data is unchanged.
  - Else if hold_full: out_data<=hold_data, hold_full<=0, sent_cnt++.
  - Else (underrun): out_data<=0x00, underrun<=1, sent_cnt++, acc_cnt++ (slot burned). The frame stays exactly TOTAL bytes.
- out_request outside STREAM is ignored.
- DRAIN: wait for tx_idle==1, then go to LATCH with counter=0.
- Same-cycle accept and out_request is impossible by construction (in_ready needs !hold_full). Maximum throughput is 1 byte per 2 cycles, far above WS2812 needs.
- underrun clears only on rst.
- LED_COUNT=1 is legal: 3 bytes per frame.

Optional Feature:
- Macro: WS2812_SCHED_HOLD_ON_UNDERRUN_EN.
- Defined: on underrun, out_data keeps its previous value (last byte repeats) instead of 0x00. underrun is still flagged and the slot is still burned.
- Undefined: underrun outputs 0x00.

Test Plan:
- All scenarios use LED_COUNT=2 (TOTAL=6) and LATCH_CYCLES=10.
- Reset release: in_ready=0 and frame_sync=0 for 10 cycles, then frame_sync pulses once and in_ready=1 in the following cycle. All outputs are 0 during rst.
- Normal frame: upstream supplies 0x11..0x66 with in_valid held high; tx_idle=0 while streaming. Required: out_start pulses once with out_data=0x11; successive requests give 0x22,0x33,0x44,0x55,0x66; 6th request enters DRAIN; tx_idle=1 gives 10 latch cycles then frame_sync. Exactly 6 accepts occur; in_ready stays 0 after the 6th until the next frame_sync.
- Underrun: drop in_valid after 0x22 until after the 3rd request, then supply 0x44,0x55,0x66. Required: out_data sequence 11,22,00,44,55,66 and underrun=1 from the 3rd request onward.
- Reset mid-stream: assert rst after the 4th request. Required: outputs go to 0 asynchronously; after release the latch gap repeats and the next frame starts at byte 1.
- Stray and late requests: out_request during LATCH or FILL has no effect (sent_cnt=0). tx_idle held 0 keeps DRAIN indefinitely with busy=1.
- Macro defined: underrun scenario yields 11,22,22,44,55,66 with underrun=1.
